// File: rtl/conway_step_controller.sv
// conway_step_controller: Moore sequencer for the Game of Life array/memory
// write pipeline. It sweeps positions 0..3 with four phases each:
//   phase 0 setup, phase 1 write_array, phase 2 settle, phase 3 write_mem.
// After the sweep it holds run high for RUN_CYCLES cycles, then starts over.
// Optional build macro CONTROLLER_PAUSE_EN adds a pause input that freezes
// the state and the run counter while it is high (reset still wins).
module conway_step_controller #(
  parameter int unsigned RUN_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
`ifdef CONTROLLER_PAUSE_EN
  input  logic       pause,
`endif
  output logic       write_array,
  output logic       run,
  output logic [1:0] pos,
  output logic       write_mem
);

  typedef enum logic {
    MODE_SWEEP = 1'b0,
    MODE_RUN   = 1'b1
  } mode_t;

  // Last counter value in RUN; the counter starts at 0 on entry.
  localparam logic [7:0] RUN_LAST = 8'(RUN_CYCLES - 1);

  mode_t      mode_q, mode_d;
  logic [1:0] pos_q, pos_d;
  logic [1:0] phase_q, phase_d;
  logic [7:0] cnt_q, cnt_d;
  logic       hold;

`ifdef CONTROLLER_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  // State register: synchronous reset returns to S0.0.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q  <= MODE_SWEEP;
      pos_q   <= 2'd0;
      phase_q <= 2'd0;
      cnt_q   <= 8'd0;
    end else begin
      mode_q  <= mode_d;
      pos_q   <= pos_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: one step per cycle unless held.
  always_comb begin
    mode_d  = mode_q;
    pos_d   = pos_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    if (!hold) begin
      case (mode_q)
        MODE_SWEEP: begin
          if (phase_q == 2'd3) begin
            phase_d = 2'd0;
            if (pos_q == 2'd3) begin
              mode_d = MODE_RUN;
              pos_d  = 2'd0;
              cnt_d  = 8'd0;
            end else begin
              pos_d = pos_q + 2'd1;
            end
          end else begin
            phase_d = phase_q + 2'd1;
          end
        end
        MODE_RUN: begin
          if (cnt_q == RUN_LAST) begin
            mode_d  = MODE_SWEEP;
            pos_d   = 2'd0;
            phase_d = 2'd0;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: begin
          mode_d  = MODE_SWEEP;
          pos_d   = 2'd0;
          phase_d = 2'd0;
          cnt_d   = 8'd0;
        end
      endcase
    end
  end

  // Moore output decode from the state register only.
  always_comb begin
    write_array = 1'b0;
    write_mem   = 1'b0;
    run         = 1'b0;
    pos         = 2'd0;
    case (mode_q)
      MODE_SWEEP: begin
        pos         = pos_q;
        write_array = (phase_q == 2'd1);
        write_mem   = (phase_q == 2'd3);
      end
      MODE_RUN: begin
        run = 1'b1;
      end
      default: begin
        run = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_conway_step_controller.sv
// Bench for conway_step_controller: two instances (RUN_CYCLES 1 and 3)
// share clock, reset and pause; each is tracked by a loop-time model.
module tb_conway_step_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pause = 1'b0;
  logic       wa_a, run_a, wm_a, wa_b, run_b, wm_b;
  logic [1:0] pos_a, pos_b;

  int n_cmp = 0;
  int n_fail = 0;
  int t_a = 0;
  int t_b = 0;

  localparam int RA = 1;
  localparam int RB = 3;

  always #5 clk = ~clk;

  conway_step_controller #(.RUN_CYCLES(RA)) dut_a (
    .clk(clk), .reset(reset),
`ifdef CONTROLLER_PAUSE_EN
    .pause(pause),
`endif
    .write_array(wa_a), .run(run_a), .pos(pos_a), .write_mem(wm_a));

  conway_step_controller #(.RUN_CYCLES(RB)) dut_b (
    .clk(clk), .reset(reset),
`ifdef CONTROLLER_PAUSE_EN
    .pause(pause),
`endif
    .write_array(wa_b), .run(run_b), .pos(pos_b), .write_mem(wm_b));

  // Expected {write_array, run, write_mem, pos} at time t within the loop:
  // t 0..15 are the sweep (pos = t/4, phase = t%4), anything later is RUN.
  function automatic logic [4:0] model_out(int t);
    int p, ph;
    logic [1:0] pv;
    if (t < 16) begin
      p  = t / 4;
      ph = t % 4;
      pv = p[1:0];
      return {(ph == 1), 1'b0, (ph == 3), pv};
    end
    return 5'b01000;
  endfunction

  function automatic logic [4:0] act_a();
    return {wa_a, run_a, wm_a, pos_a};
  endfunction

  function automatic logic [4:0] act_b();
    return {wa_b, run_b, wm_b, pos_b};
  endfunction

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {wa,run,wm,pos}=%b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: advance the models with the applied inputs, then compare.
  task automatic step();
    logic pz;
`ifdef CONTROLLER_PAUSE_EN
    pz = pause;
`else
    pz = 1'b0;
`endif
    @(posedge clk);
    if (reset) begin
      t_a = 0;
      t_b = 0;
    end else if (!pz) begin
      t_a = (t_a + 1) % (16 + RA);
      t_b = (t_b + 1) % (16 + RB);
    end
    #1;
    chk("model_a", act_a(), model_out(t_a));
    chk("model_b", act_b(), model_out(t_b));
  endtask

  typedef struct {
    logic       rst;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[20];
  int   wa_hits[$];
  int   run_len, run_seen;

  initial begin
    // Reset then first sweep, RUN and restart for RUN_CYCLES = 1.
    vecs[0]  = '{1'b1, 5'b00000};
    vecs[1]  = '{1'b0, 5'b10000};
    vecs[2]  = '{1'b0, 5'b00000};
    vecs[3]  = '{1'b0, 5'b00100};
    vecs[4]  = '{1'b0, 5'b00001};
    vecs[5]  = '{1'b0, 5'b10001};
    vecs[6]  = '{1'b0, 5'b00001};
    vecs[7]  = '{1'b0, 5'b00101};
    vecs[8]  = '{1'b0, 5'b00010};
    vecs[9]  = '{1'b0, 5'b10010};
    vecs[10] = '{1'b0, 5'b00010};
    vecs[11] = '{1'b0, 5'b00110};
    vecs[12] = '{1'b0, 5'b00011};
    vecs[13] = '{1'b0, 5'b10011};
    vecs[14] = '{1'b0, 5'b00011};
    vecs[15] = '{1'b0, 5'b00111};
    vecs[16] = '{1'b0, 5'b01000};
    vecs[17] = '{1'b0, 5'b00000};
    vecs[18] = '{1'b0, 5'b10000};
    vecs[19] = '{1'b0, 5'b00000};

    reset = 1'b1;
    pause = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      reset = vecs[i].rst;
      step();
      chk($sformatf("table[%0d]", i), act_a(), vecs[i].exp);
    end

    // RUN_CYCLES = 3: run length and loop period between pos-0 write_array.
    reset = 1'b1; step();
    reset = 1'b0;
    run_len = 0; run_seen = -1;
    for (int c = 0; c < 100 && (wa_hits.size() < 2 || run_seen < 0); c++) begin
      step();
      if (wa_b && pos_b == 2'd0) wa_hits.push_back(c);
      if (run_b) run_len++;
      else if (run_len > 0 && run_seen < 0) run_seen = run_len;
    end
    chk_int("run_len_b", run_seen, RB);
    if (wa_hits.size() >= 2) chk_int("period_b", wa_hits[1] - wa_hits[0], 16 + RB);
    else chk_int("period_b", -1, 16 + RB);

    // Reset asserted at S2.1.
    reset = 1'b1; step();
    reset = 1'b0;
    for (int i = 0; i < 9; i++) step();
    chk("at_S2_1", act_a(), 5'b10010);
    reset = 1'b1; step();
    chk("rst_S2_1", act_a(), 5'b00000);
    reset = 1'b0; step();
    chk("restart_S2_1", act_a(), 5'b10000);

    // Reset asserted during RUN of the RUN_CYCLES = 3 instance.
    reset = 1'b1; step();
    reset = 1'b0;
    for (int i = 0; i < 17; i++) step();
    chk("in_run_b", act_b(), 5'b01000);
    reset = 1'b1; step();
    chk("rst_run_b", act_b(), 5'b00000);
    reset = 1'b0; step();
    chk("restart_run_b", act_b(), 5'b10000);

`ifdef CONTROLLER_PAUSE_EN
    // Pause for 5 cycles at S1.1, then resume into S1.2.
    reset = 1'b1; step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("at_S1_1", act_a(), 5'b10001);
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("pause_hold[%0d]", i), act_a(), 5'b10001);
    end
    pause = 1'b0; step();
    chk("pause_release", act_a(), 5'b00001);
    // Reset overrides pause.
    pause = 1'b1; reset = 1'b1; step();
    chk("rst_over_pause", act_a(), 5'b00000);
    pause = 1'b0; reset = 1'b0;
`endif

    // Randomized run against the models.
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 39) == 0);
`ifdef CONTROLLER_PAUSE_EN
      pause = ($urandom_range(0, 3) == 0);
`endif
      step();
    end
    reset = 1'b0;
    pause = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
